// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_unit_pkg;

  localparam logic [31:0] NOP_INSN_DEF = 32'h0000_0013;  // ADDI x0,x0,0
  localparam logic        TRUE         = 1'b1;
  localparam logic        FALSE        = 1'b0;

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_RUN   = 2'd1,
    S_REDIR = 2'd2
  } fetch_state_e;

  // One buffered fetch result: PC in the upper half, instruction word below.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] insn;
  } fetch_entry_t;

  // Redirect targets are forced to a word boundary.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry circular buffer of {pc, insn} pairs between imem and decode.
module fetch_fifo
  import fetch_unit_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t wdata,
  output fetch_entry_t head,
  output logic [1:0]   count
);

  fetch_entry_t mem [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic         do_push;
  logic         do_pop;

  // The fetch issue rule keeps the buffer from overflowing; the full guard only
  // protects the stored entries should that ever be violated.
  assign do_push = push && (count != 2'd2);
  assign do_pop  = pop && (count != 2'd0);
  assign head    = mem[rd_ptr];

  // Pointer, occupancy and storage update; flush wins over push/pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: drives a synchronous imem, buffers returned words
// with their PCs and hands them to decode under a valid/ready handshake.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_BOOT  | single idle cycle after reset, no fetch
// S_RUN   | normal fetch, issue whenever the buffer has room
// S_REDIR | bubble cycle after a redirect while the new PC settles
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INSN = NOP_INSN_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_en,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        id_ready,
  output logic [31:0] ir,
  output logic [31:0] ir_pc,
  output logic        ir_valid
);

  fetch_state_e state_q;
  logic [31:0]  pc_q;
  logic [31:0]  tag_q;
  logic         inflight_q;
  logic         drop_q;

  logic         pop;
  logic         issue;
  logic         push;
  logic [2:0]   occupancy;
  logic [1:0]   fifo_count;
  fetch_entry_t fifo_head;
  fetch_entry_t fifo_wdata;

  // Decoder consumes the head word; buffer slots that will be in use next
  // cycle are what is queued plus what is in flight, minus what leaves now.
  assign pop       = ir_valid && id_ready;
  assign occupancy = {1'b0, fifo_count} + {2'b00, inflight_q} - {2'b00, pop};
  assign issue     = (state_q == S_RUN) && !redirect_valid && (occupancy < 3'd2);

  assign imem_en   = issue;
  assign imem_addr = pc_q;

  // A redirect this cycle squashes the response arriving now.
  assign push       = inflight_q && !drop_q && !redirect_valid;
  assign fifo_wdata = '{pc: tag_q, insn: imem_rdata};

  fetch_fifo u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop && !redirect_valid),
    .flush (redirect_valid),
    .wdata (fifo_wdata),
    .head  (fifo_head),
    .count (fifo_count)
  );

  // Decode sees a NOP and a zero PC whenever nothing valid is buffered.
  assign ir_valid = (fifo_count != 2'd0);
  assign ir       = ir_valid ? fifo_head.insn : NOP_INSN;
  assign ir_pc    = ir_valid ? fifo_head.pc   : 32'h0000_0000;

  // Fetch state, PC, in-flight tracking; redirect has priority over issue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_BOOT;
      pc_q       <= RESET_PC;
      tag_q      <= 32'h0000_0000;
      inflight_q <= FALSE;
      drop_q     <= FALSE;
    end else if (redirect_valid) begin
      state_q    <= S_REDIR;
      pc_q       <= align_word(redirect_pc);
      drop_q     <= inflight_q;
      inflight_q <= FALSE;
    end else begin
      drop_q <= FALSE;
      case (state_q)
        S_BOOT:  state_q <= S_RUN;
        S_REDIR: state_q <= S_RUN;
        S_RUN:   state_q <= S_RUN;
        default: state_q <= S_BOOT;
      endcase
      if (issue) begin
        pc_q       <= pc_q + 32'd4;
        tag_q      <= pc_q;
        inflight_q <= TRUE;
      end else begin
        inflight_q <= FALSE;
      end
    end
  end

endmodule
